// File: rtl/pe_seq_pkg.sv
// Shared types and widths for the PE sequencer: FSM state encoding and operand/sum widths.
package pe_seq_pkg;

  localparam int unsigned W_OP  = 8;
  localparam int unsigned W_SUM = 24;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } pe_seq_state_e;

endpackage

// File: rtl/pe_seq_ctrl_if.sv
// Command, operand-stream and result handshakes of the PE sequencer.
interface pe_seq_ctrl_if #(
  parameter int unsigned LEN_W = 8
);
  import pe_seq_pkg::*;

  logic                cmd_valid;
  logic                cmd_ready;
  logic [LEN_W-1:0]    cmd_len;
  logic [W_SUM-1:0]    cmd_bias;

  logic                in_valid;
  logic                in_ready;
  logic [W_OP-1:0]     in_weight;
  logic [W_OP-1:0]     in_act;

  logic                res_valid;
  logic                res_ready;
  logic [W_SUM-1:0]    res_sum;

  modport master (
    output cmd_valid, cmd_len, cmd_bias, in_valid, in_weight, in_act, res_ready,
    input  cmd_ready, in_ready, res_valid, res_sum
  );

  modport slave (
    input  cmd_valid, cmd_len, cmd_bias, in_valid, in_weight, in_act, res_ready,
    output cmd_ready, in_ready, res_valid, res_sum
  );

endinterface

// File: rtl/pe_seq_cnt.sv
// Remaining-beat counter: load on command accept, decrement per beat, flag when empty.
module pe_seq_cnt #(
  parameter int unsigned Width = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             dec,
  output logic [Width-1:0] count,
  output logic             zero
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - Width'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/pe_seq_ctrl.sv
// Sequences one dot-product job through an external registered PE.
// Optional stall counter enabled by defining PE_SEQ_STALL_CNT_EN.
module pe_seq_ctrl
  import pe_seq_pkg::*;
#(
  parameter int unsigned LEN_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  pe_seq_ctrl_if.slave       bus,
  output logic [W_OP-1:0]    pe_weight,
  output logic [W_OP-1:0]    pe_activation,
  output logic [W_SUM-1:0]   pe_sum,
  input  logic [W_SUM-1:0]   pe_o_sum,
  output logic               busy
`ifdef PE_SEQ_STALL_CNT_EN
  ,
  output logic [15:0]        stall_cnt
`endif
);

  pe_seq_state_e    state_q, state_d;
  logic [W_SUM-1:0] bias_q, bias_d;
  logic [W_SUM-1:0] res_sum_q, res_sum_d;
  logic             first_q, first_d;
  logic             cmd_accept;
  logic             cnt_dec;
  logic             cnt_zero;
  logic [LEN_W-1:0] cnt;

  pe_seq_cnt #(
    .Width (LEN_W)
  ) u_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (cmd_accept),
    .load_val (bus.cmd_len),
    .dec      (cnt_dec),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  // cmd_ready is gated by reset so it reads 0 while reset is held.
  assign bus.cmd_ready = (state_q == StIdle) && reset;
  assign cmd_accept    = bus.cmd_valid && bus.cmd_ready;
  assign bus.res_sum   = res_sum_q;

  always_comb begin
    state_d       = state_q;
    bias_d        = bias_q;
    res_sum_d     = res_sum_q;
    first_d       = first_q;
    cnt_dec       = 1'b0;
    bus.in_ready  = 1'b0;
    bus.res_valid = 1'b0;
    pe_weight     = '0;
    pe_activation = '0;
    pe_sum        = '0;
    busy          = 1'b1;
    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (cmd_accept) begin
          bias_d  = bus.cmd_bias;
          first_d = 1'b1;
          state_d = (bus.cmd_len == '0) ? StDrain : StRun;
        end
      end
      StRun: begin
        bus.in_ready = !cnt_zero;
        // Bubbles feed zero operands so the PE recirculates the partial sum.
        pe_sum = first_q ? bias_q : pe_o_sum;
        if (bus.in_valid && bus.in_ready) begin
          pe_weight     = bus.in_weight;
          pe_activation = bus.in_act;
          first_d       = 1'b0;
          cnt_dec       = 1'b1;
          if (cnt == LEN_W'(1)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        // first_q still set here only for an empty job.
        res_sum_d = first_q ? bias_q : pe_o_sum;
        state_d   = StDone;
      end
      StDone: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      bias_q    <= '0;
      res_sum_q <= '0;
      first_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bias_q    <= bias_d;
      res_sum_q <= res_sum_d;
      first_q   <= first_d;
    end
  end

`ifdef PE_SEQ_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (cmd_accept) begin
      stall_q <= '0;
    end else if ((state_q == StRun) && !bus.in_valid && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Bench for pe_seq_ctrl with a behavioural registered PE and a sum/latency reference model.
module tb_pe_seq_ctrl;

  logic        clock;
  logic        reset;
  logic [7:0]  pe_weight;
  logic [7:0]  pe_activation;
  logic [23:0] pe_sum;
  logic [23:0] pe_o_sum;
  logic        busy;
`ifdef PE_SEQ_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  int w_q   [0:15];
  int a_q   [0:15];
  int gap_q [0:15];

  pe_seq_ctrl_if #(.LEN_W(8)) bus ();

  pe_seq_ctrl #(
    .LEN_W (8)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .bus           (bus),
    .pe_weight     (pe_weight),
    .pe_activation (pe_activation),
    .pe_sum        (pe_sum),
    .pe_o_sum      (pe_o_sum),
    .busy          (busy)
`ifdef PE_SEQ_STALL_CNT_EN
    ,
    .stall_cnt     (stall_cnt)
`endif
  );

  // External PE: one-cycle registered multiply-accumulate, modulo 2^24.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) pe_o_sum <= '0;
    else        pe_o_sum <= pe_sum + 24'(pe_weight * pe_activation);
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag, input logic exp_cmd_ready);
    check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'(exp_cmd_ready));
    check({tag, "_in_ready"}, 32'(bus.in_ready), 0);
    check({tag, "_res_valid"}, 32'(bus.res_valid), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_pe_w"}, 32'(pe_weight), 0);
    check({tag, "_pe_a"}, 32'(pe_activation), 0);
    check({tag, "_pe_sum"}, 32'(pe_sum), 0);
  endtask

  // Runs one job from IDLE; expected sum is bias plus the dot product of the beats.
  task automatic run_job(input int len, input logic [23:0] bias, input int hold);
    logic [23:0] run;
    int          stalls;
    run    = bias;
    stalls = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = len[7:0];
    bus.cmd_bias  = bias;
    #1 check("cmd_ready", 32'(bus.cmd_ready), 1);
    @(negedge clock);
    bus.cmd_valid = 1'b0;
    bus.cmd_len   = 8'($urandom);
    bus.cmd_bias  = 24'($urandom);
    for (int i = 0; i < len; i++) begin
      for (int g = 0; g < gap_q[i]; g++) begin
        bus.in_valid  = 1'b0;
        bus.in_weight = 8'($urandom);
        bus.in_act    = 8'($urandom);
        #1;
        check("bubble_w", 32'(pe_weight), 0);
        check("bubble_sum", 32'(pe_sum), 32'(run));
        check("bubble_in_ready", 32'(bus.in_ready), 1);
        stalls++;
        @(negedge clock);
      end
      bus.in_valid  = 1'b1;
      bus.in_weight = 8'(w_q[i]);
      bus.in_act    = 8'(a_q[i]);
      #1;
      check("beat_w", 32'(pe_weight), 32'(w_q[i] & 8'hFF));
      check("beat_a", 32'(pe_activation), 32'(a_q[i] & 8'hFF));
      check("beat_sum", 32'(pe_sum), 32'(run));
      run = run + 24'(w_q[i] * a_q[i]);
      @(negedge clock);
      bus.in_valid = 1'b0;
    end
    #1;
    check("drain_res_valid", 32'(bus.res_valid), 0);
    check("drain_in_ready", 32'(bus.in_ready), 0);
    check("drain_busy", 32'(busy), 1);
    @(negedge clock);
    #1;
    check("res_valid_latency", 32'(bus.res_valid), 1);
    check("res_sum", 32'(bus.res_sum), 32'(run));
    check("done_in_ready", 32'(bus.in_ready), 0);
    for (int h = 0; h < hold; h++) begin
      bus.res_ready = 1'b0;
      bus.cmd_valid = 1'b1;
      bus.in_valid  = 1'b1;
      @(negedge clock);
      #1;
      check("hold_res_valid", 32'(bus.res_valid), 1);
      check("hold_res_sum", 32'(bus.res_sum), 32'(run));
      check("hold_cmd_ready", 32'(bus.cmd_ready), 0);
      check("hold_pe_w", 32'(pe_weight), 0);
    end
    bus.cmd_valid = 1'b0;
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b1;
    @(negedge clock);
    bus.res_ready = 1'b0;
    #1;
    check("post_res_valid", 32'(bus.res_valid), 0);
    check("post_cmd_ready", 32'(bus.cmd_ready), 1);
    check("post_busy", 32'(busy), 0);
    check("post_res_sum_kept", 32'(bus.res_sum), 32'(run));
`ifdef PE_SEQ_STALL_CNT_EN
    check("stall_cnt", 32'(stall_cnt), 32'(stalls));
`endif
  endtask

  initial begin
    reset         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_len   = '0;
    bus.cmd_bias  = '0;
    bus.in_valid  = 1'b0;
    bus.in_weight = '0;
    bus.in_act    = '0;
    bus.res_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      w_q[i] = 0; a_q[i] = 0; gap_q[i] = 0;
    end
    repeat (2) @(negedge clock);
    #1 check_idle_outputs("in_reset", 1'b0);
    check("in_reset_res_sum", 32'(bus.res_sum), 0);
    @(negedge clock);
    reset = 1'b1;
    #1 check_idle_outputs("after_reset", 1'b1);
    @(negedge clock);

    // Back-to-back three-beat job.
    w_q[0] = 2; a_q[0] = 3; w_q[1] = 4; a_q[1] = 5; w_q[2] = 1; a_q[2] = 1;
    run_job(3, 24'h000010, 0);
    check("job3_literal", 32'(bus.res_sum), 32'h2B);

    // Empty job returns the bias.
    run_job(0, 24'hABCDEF, 1);

    // Wrap modulo 2^24.
    w_q[0] = 1; a_q[0] = 1;
    run_job(1, 24'hFFFFFF, 0);
    check("wrap_literal", 32'(bus.res_sum), 0);

    // Three bubbles between two beats.
    w_q[0] = 3; a_q[0] = 3; w_q[1] = 2; a_q[1] = 2; gap_q[1] = 3;
    run_job(2, 24'h000100, 0);
    check("bubble_literal", 32'(bus.res_sum), 32'h10D);
    gap_q[1] = 0;

    // Result held for five cycles.
    w_q[0] = 7; a_q[0] = 9;
    run_job(1, 24'h123456, 5);

    // Reset after one of four beats discards the job.
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = 8'd4;
    bus.cmd_bias  = 24'h000055;
    @(negedge clock);
    bus.cmd_valid = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_weight = 8'd6;
    bus.in_act    = 8'd6;
    @(negedge clock);
    bus.in_valid  = 1'b1;
    #2 reset = 1'b0;
    #1 check_idle_outputs("midjob_reset", 1'b0);
    check("midjob_reset_res_sum", 32'(bus.res_sum), 0);
    bus.in_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1 check("reset_release_cmd_ready", 32'(bus.cmd_ready), 1);
    repeat (3) begin
      @(negedge clock);
      #1 check("no_stale_result", 32'(bus.res_valid), 0);
    end
    @(negedge clock);
    w_q[0] = 5; a_q[0] = 5;
    run_job(1, 24'h000000, 0);
    check("after_reset_literal", 32'(bus.res_sum), 32'h19);

    // Randomised jobs with random bubbles and result back-pressure.
    for (int j = 0; j < 25; j++) begin
      int len;
      len = $urandom_range(0, 8);
      for (int i = 0; i < 16; i++) begin
        w_q[i]   = $urandom_range(0, 255);
        a_q[i]   = $urandom_range(0, 255);
        gap_q[i] = $urandom_range(0, 2);
      end
      run_job(len, 24'($urandom), $urandom_range(0, 3));
      @(negedge clock);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
